// File: rtl/lane_scan_pkg.sv
// Shared definitions for the falling-box display scan blocks.
// Contents:
//   calc_xw / calc_yw / calc_lw - port widths derived from COLS, ROWS, LANES
//   lane_t                      - container type for lane codes
//   empty_code                  - code meaning "no box in this row" (equal to LANES)
package lane_scan_pkg;

  localparam int unsigned LaneWMax = 8;

  typedef logic [LaneWMax-1:0] lane_t;

  function automatic int unsigned calc_xw(int unsigned cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int unsigned calc_yw(int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // One extra code above the lane range encodes an empty row.
  function automatic int unsigned calc_lw(int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic lane_t empty_code(int unsigned lanes);
    return lane_t'(lanes);
  endfunction

endpackage

// File: rtl/lane_scan_driver_if.sv
// Box handshake between the upstream generator and lane_scan_driver.
// Signals:
//   lane_in / lane_valid / lane_ready - new top-row lane code, sampled in the step cycle
//   landed_valid / landed_lane        - box leaving the bottom row
// Modports: master = generator side, slave = scan driver side.
interface lane_scan_driver_if #(
  parameter int unsigned LANES = 4
);
  import lane_scan_pkg::*;

  localparam int unsigned LW = calc_lw(LANES);

  logic [LW-1:0] lane_in;
  logic          lane_valid;
  logic          lane_ready;
  logic          landed_valid;
  logic [LW-1:0] landed_lane;

  modport master (
    output lane_in,
    output lane_valid,
    input  lane_ready,
    input  landed_valid,
    input  landed_lane
  );

  modport slave (
    input  lane_in,
    input  lane_valid,
    output lane_ready,
    output landed_valid,
    output landed_lane
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick_o while the count is DIV-1.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   tick_o - one-cycle pulse every DIV cycles (every cycle when DIV == 1)
module tick_prescaler #(
  parameter int unsigned DIV = 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_end;

  assign at_end = (cnt_q == CW'(DIV - 1));
  assign cnt_d  = at_end ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Qualified by reset so a DIV == 1 build still reads 0 while held in reset.
  assign tick_o = at_end & rst_ni;

endmodule

// File: rtl/lane_scan_driver.sv
// Dot-matrix scan driver for the falling-box display.
// Holds one lane code per row, rasters it onto a COLS x ROWS LED matrix at the prescaled
// tick rate and shifts the boxes down one row every FRAMES_PER_STEP completed frames.
// Ports:
//   CLK, RSTn                  - clock, asynchronous active-low reset
//   lane_if (slave)            - new top-row boxes in, landed boxes out
//   x_out, y_out               - current scan column / row (ROWS-1 is top)
//   pix_on                     - LED at (x_out, y_out) is lit
//   scan_tick                  - pulse in the cycle the scan position advances
// Build option: define LANE_SCAN_BLANK_SKIP_EN to raster only lit pixels (one tick per
// empty row); otherwise every pixel of the matrix is visited.
module lane_scan_driver import lane_scan_pkg::*; #(
  parameter  int unsigned COLS            = 8,
  parameter  int unsigned ROWS            = 16,
  parameter  int unsigned LANES           = 4,
  parameter  int unsigned DIV             = 10000,
  parameter  int unsigned FRAMES_PER_STEP = 8,
  localparam int unsigned XW              = calc_xw(COLS),
  localparam int unsigned YW              = calc_yw(ROWS),
  localparam int unsigned LW              = calc_lw(LANES)
) (
  input  logic                CLK,
  input  logic                RSTn,
  lane_scan_driver_if.slave   lane_if,
  output logic [XW-1:0]       x_out,
  output logic [YW-1:0]       y_out,
  output logic                pix_on,
  output logic                scan_tick
);

  localparam int unsigned    W     = COLS / LANES;
  localparam int unsigned    FW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [LW-1:0]  Empty = LW'(empty_code(LANES));

  logic            tick;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [LW-1:0]   rows_q [ROWS];
  logic [LW-1:0]   rows_d [ROWS];
  logic            landed_valid_q, landed_valid_d;
  logic [LW-1:0]   landed_lane_q, landed_lane_d;
  logic [LW-1:0]   cur_lane;
  logic [LW-1:0]   top_in;
  logic            row_last;
  logic            step;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .tick_o (tick)
  );

  // First column of a lane; empty rows park at column 0.
  function automatic logic [XW-1:0] lane_start(logic [LW-1:0] lane);
    return (lane == Empty) ? '0 : XW'(32'(lane) * W);
  endfunction

  always_comb begin
    cur_lane = rows_q[y_q];
    pix_on   = (cur_lane != Empty) && ((32'(x_q) / W) == 32'(cur_lane));
  end

  always_comb begin
    x_d            = x_q;
    y_d            = y_q;
    frame_d        = frame_q;
    rows_d         = rows_q;
    landed_valid_d = 1'b0;
    landed_lane_d  = landed_lane_q;
    step           = 1'b0;
    top_in         = (lane_if.lane_valid && (lane_if.lane_in < LW'(LANES))) ? lane_if.lane_in
                                                                           : Empty;
`ifdef LANE_SCAN_BLANK_SKIP_EN
    row_last = (cur_lane == Empty) || (32'(x_q) >= 32'(lane_start(cur_lane)) + W - 1);
`else
    row_last = (x_q == XW'(COLS - 1));
`endif

    if (tick) begin
      if (!row_last) begin
        x_d = x_q + 1'b1;
      end else if (y_q == '0) begin
        y_d = YW'(ROWS - 1);
        if (frame_q == FW'(FRAMES_PER_STEP - 1)) begin
          step    = 1'b1;
          frame_d = '0;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        y_d = y_q - 1'b1;
      end
    end

    // Shift only at the frame boundary so a frame never mixes two buffer states.
    if (step) begin
      for (int i = 0; i < ROWS - 1; i++) begin
        rows_d[i] = rows_q[i+1];
      end
      rows_d[ROWS-1] = top_in;
      if (rows_q[0] != Empty) begin
        landed_valid_d = 1'b1;
        landed_lane_d  = rows_q[0];
      end
    end

    if (tick && row_last) begin
`ifdef LANE_SCAN_BLANK_SKIP_EN
      // Row entry uses the post-step buffer so a freshly loaded top row starts correctly.
      x_d = lane_start(rows_d[y_d]);
`else
      x_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      x_q            <= '0;
      y_q            <= YW'(ROWS - 1);
      frame_q        <= '0;
      landed_valid_q <= 1'b0;
      landed_lane_q  <= '0;
      for (int i = 0; i < ROWS; i++) begin
        rows_q[i] <= Empty;
      end
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      frame_q        <= frame_d;
      landed_valid_q <= landed_valid_d;
      landed_lane_q  <= landed_lane_d;
      rows_q         <= rows_d;
    end
  end

  assign x_out                = x_q;
  assign y_out                = y_q;
  assign scan_tick            = tick;
  assign lane_if.lane_ready   = step;
  assign lane_if.landed_valid = landed_valid_q;
  assign lane_if.landed_lane  = landed_lane_q;

endmodule

// File: tb/tb_lane_scan_driver.sv
// Randomized bench for lane_scan_driver (COLS=8, ROWS=4, LANES=4, DIV=3, FRAMES_PER_STEP=2).
// The reference model keeps the buffer as an array of lane codes and each frame as a list
// of (x, y) positions built from the display rules; the DUT is checked every cycle.
module tb_lane_scan_driver;

  localparam int unsigned ColsP  = 8;
  localparam int unsigned RowsP  = 4;
  localparam int unsigned LanesP = 4;
  localparam int unsigned DivP   = 3;
  localparam int unsigned FpsP   = 2;
  localparam int          WP     = ColsP / LanesP;
  localparam int          EmptyP = LanesP;
`ifdef LANE_SCAN_BLANK_SKIP_EN
  localparam int          DirLane = 1;
`else
  localparam int          DirLane = 2;
`endif

  typedef struct {
    int x;
    int y;
  } pos_t;

  logic       CLK;
  logic       RSTn;
  logic [2:0] x_out;
  logic [1:0] y_out;
  logic       pix_on;
  logic       scan_tick;

  int n_checks;
  int n_fail;

  int   m_rows [RowsP];
  pos_t frame_pos[$];
  int   pos_idx;
  int   frames_done;
  int   steps_done;
  int   cyc;
  int   exp_lv;
  int   exp_ll;

  lane_scan_driver_if #(.LANES(LanesP)) lif ();

  lane_scan_driver #(
    .COLS            (ColsP),
    .ROWS            (RowsP),
    .LANES           (LanesP),
    .DIV             (DivP),
    .FRAMES_PER_STEP (FpsP)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .lane_if   (lif),
    .x_out     (x_out),
    .y_out     (y_out),
    .pix_on    (pix_on),
    .scan_tick (scan_tick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Positions visited in one frame for the current buffer contents.
  function automatic void build_frame();
    pos_t p;
    frame_pos.delete();
    for (int y = RowsP - 1; y >= 0; y--) begin
`ifdef LANE_SCAN_BLANK_SKIP_EN
      if (m_rows[y] == EmptyP) begin
        p.x = 0;
        p.y = y;
        frame_pos.push_back(p);
      end else begin
        for (int k = 0; k < WP; k++) begin
          p.x = m_rows[y] * WP + k;
          p.y = y;
          frame_pos.push_back(p);
        end
      end
`else
      for (int x = 0; x < ColsP; x++) begin
        p.x = x;
        p.y = y;
        frame_pos.push_back(p);
      end
`endif
    end
  endfunction

  task automatic reset_model();
    for (int i = 0; i < RowsP; i++) m_rows[i] = EmptyP;
    pos_idx     = 0;
    frames_done = 0;
    steps_done  = 0;
    cyc         = 0;
    exp_lv      = 0;
    exp_ll      = 0;
    build_frame();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_x"}, int'(x_out), 0);
    check_eq({pfx, "_y"}, int'(y_out), RowsP - 1);
    check_eq({pfx, "_pix"}, int'(pix_on), 0);
    check_eq({pfx, "_tick"}, int'(scan_tick), 0);
    check_eq({pfx, "_ready"}, int'(lif.lane_ready), 0);
    check_eq({pfx, "_lv"}, int'(lif.landed_valid), 0);
    check_eq({pfx, "_ll"}, int'(lif.landed_lane), 0);
  endtask

  // Starts and ends on a falling edge; inputs for the cycle are set first.
  task automatic run_cycles(input int n);
    int   exp_tick, exp_step, is_last, lane, exp_pix, top;
    pos_t cur;
    for (int i = 0; i < n; i++) begin
      if (steps_done < 5) begin
        lif.lane_valid = 1'b1;
        lif.lane_in    = 3'(DirLane);
      end else if (steps_done == 5) begin
        lif.lane_valid = 1'b1;
        lif.lane_in    = 3'd7;
      end else begin
        lif.lane_valid = 1'($urandom_range(0, 1));
        lif.lane_in    = 3'($urandom_range(0, 7));
      end
      #1;
      exp_tick = ((cyc % DivP) == DivP - 1) ? 1 : 0;
      is_last  = (pos_idx == frame_pos.size() - 1) ? 1 : 0;
      exp_step = (exp_tick && is_last && ((frames_done % FpsP) == FpsP - 1)) ? 1 : 0;
      cur      = frame_pos[pos_idx];
      lane     = m_rows[cur.y];
      exp_pix  = (lane != EmptyP && (cur.x / WP) == lane) ? 1 : 0;

      check_eq("x_out", int'(x_out), cur.x);
      check_eq("y_out", int'(y_out), cur.y);
      check_eq("pix_on", int'(pix_on), exp_pix);
      check_eq("scan_tick", int'(scan_tick), exp_tick);
      check_eq("lane_ready", int'(lif.lane_ready), exp_step);
      check_eq("landed_valid", int'(lif.landed_valid), exp_lv);
      check_eq("landed_lane", int'(lif.landed_lane), exp_ll);

      exp_lv = 0;
      if (exp_tick != 0) begin
        if (is_last != 0) begin
          frames_done++;
          if (exp_step != 0) begin
            if (m_rows[0] != EmptyP) begin
              exp_lv = 1;
              exp_ll = m_rows[0];
            end
            top = (lif.lane_valid && int'(lif.lane_in) < LanesP) ? int'(lif.lane_in) : EmptyP;
            for (int r = 0; r < RowsP - 1; r++) m_rows[r] = m_rows[r+1];
            m_rows[RowsP-1] = top;
            steps_done++;
          end
          build_frame();
          pos_idx = 0;
        end else begin
          pos_idx++;
        end
      end
      cyc++;
      @(negedge CLK);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    RSTn           = 1'b0;
    lif.lane_valid = 1'b0;
    lif.lane_in    = '0;
    reset_model();
    repeat (3) @(negedge CLK);
    #1;
    check_reset_outputs("por");

    @(negedge CLK);
    RSTn = 1'b1;
    reset_model();
    run_cycles(2600);

    // Mid-frame reset: outputs must return to reset values without waiting for a clock.
    RSTn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge CLK);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge CLK);
    RSTn = 1'b1;
    reset_model();
    run_cycles(1400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
